// File: rtl/wb_port_arbiter_if.sv
// Write-port bus between the writeback requesters and the register-file arbiter.
// The requester side is the master; the arbiter is the slave.
interface wb_port_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 64
);
  logic [NREQ-1:0]          req;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic                     stall;
  logic [NREQ-1:0]          gnt;
  logic                     wr_en;
  logic [(1<<ADDR_W)-1:0]   wr_sel;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     busy;

  modport master (
    output req, req_addr, req_data, stall,
    input  gnt, wr_en, wr_sel, wr_addr, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data, stall,
    output gnt, wr_en, wr_sel, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port: one registered write
// per cycle, one-hot bank select decode, and optional hardwired zero register.
module wb_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 64,
  parameter int ZR_EN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NSEL  = 1 << ADDR_W;

  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              wr_en_reg, wr_en_next;
  logic [NSEL-1:0]   wr_sel_reg, wr_sel_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [NREQ-1:0]   elig;
  logic              found;
  logic [PTR_W-1:0]  win;
  logic [ADDR_W-1:0] win_addr;
  logic              zr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A requester holding its grant this cycle is still raising req; mask it.
  assign elig = bus.req & ~gnt_reg;

  always_comb begin : p_search
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign win_addr = addr_arr[win];
  assign zr_hit   = (ZR_EN != 0) && (win_addr == {ADDR_W{1'b1}});

  always_comb begin
    gnt_next     = '0;
    wr_en_next   = 1'b0;
    wr_sel_next  = '0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    ptr_next     = ptr_reg;
    if (!bus.stall && found) begin
      gnt_next[win] = 1'b1;
      wr_addr_next  = win_addr;
      wr_data_next  = data_arr[win];
      ptr_next      = (win == PTR_W'(NREQ-1)) ? '0 : win + PTR_W'(1);
      // Zero-register writes are acknowledged but never reach the bank.
      if (!zr_hit) begin
        wr_en_next            = 1'b1;
        wr_sel_next[win_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_sel_reg  <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      wr_en_reg   <= wr_en_next;
      wr_sel_reg  <= wr_sel_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_sel  = wr_sel_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign bus.busy    = bus.stall && (elig != '0);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_reg));
  a_sel_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(wr_sel_reg));
  a_sel_en:     assert property (@(posedge clk) disable iff (!reset) (wr_sel_reg != '0) |-> wr_en_reg);
  a_en_gnt:     assert property (@(posedge clk) disable iff (!reset) wr_en_reg |-> (gnt_reg != '0));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a reference model queues expected writes,
// a monitor compares them every cycle against a ZR_EN=1 and a ZR_EN=0 instance.
module tb_wb_port_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 64;
  localparam int NSEL   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  wb_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

  assign bus0.req      = bus.req;
  assign bus0.req_addr = bus.req_addr;
  assign bus0.req_data = bus.req_data;
  assign bus0.stall    = bus.stall;

  wb_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZR_EN(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  wb_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZR_EN(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  typedef struct {
    int                cyc;
    logic [NREQ-1:0]   gnt;
    logic              en;
    logic [NSEL-1:0]   sel;
    logic [NSEL-1:0]   sel0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t q[$];
  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;

  // Reference model state
  int                ptr;
  logic [NREQ-1:0]   last_gnt;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [NREQ-1:0]   owed;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: first eligible requester at/after ptr wins; wins are queued for the monitor.
  always @(posedge clk or negedge reset) begin
    exp_t            me;
    logic [NREQ-1:0] elig_m;
    int              w;
    logic [ADDR_W-1:0] a;
    if (!reset) begin
      ptr = 0; last_gnt = '0; hold_addr = '0; hold_data = '0;
      q.delete();
    end else begin
      cyc++;
      elig_m   = bus.req & ~last_gnt;
      last_gnt = '0;
      if (!bus.stall && elig_m != '0) begin
        w = ptr;
        while (!elig_m[w]) w = (w + 1) % NREQ;
        a = bus.req_addr[w*ADDR_W +: ADDR_W];
        me.cyc  = cyc;
        me.gnt  = '0;  me.gnt[w] = 1'b1;
        me.addr = a;
        me.data = bus.req_data[w*DATA_W +: DATA_W];
        me.sel0 = '0;  me.sel0[a] = 1'b1;
        me.en   = (int'(a) != NSEL - 1);
        me.sel  = me.en ? me.sel0 : '0;
        q.push_back(me);
        last_gnt[w] = 1'b1;
        hold_addr   = a;
        hold_data   = me.data;
        ptr         = (w + 1) % NREQ;
      end
    end
  end

  // Monitor: pops the write expected for this cycle, otherwise expects idle outputs.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (reset) begin
      exp_busy = bus.stall && ((bus.req & ~last_gnt) != '0);
      chk("busy", bus.busy, exp_busy);
      chk("busy0", bus0.busy, exp_busy);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        $display("TXN cyc=%0d gnt=%b addr=%0d data=%h en=%b sel=%b", cyc, bus.gnt, bus.wr_addr, bus.wr_data, bus.wr_en, bus.wr_sel);
        chk("gnt", bus.gnt, e.gnt);
        chk("wr_en", bus.wr_en, e.en);
        chk("wr_sel", bus.wr_sel, e.sel);
        chk("gnt0", bus0.gnt, e.gnt);
        chk("wr_en0", bus0.wr_en, 1);
        chk("wr_sel0", bus0.wr_sel, e.sel0);
      end else begin
        chk("idle_gnt", bus.gnt, 0);
        chk("idle_wr_en", bus.wr_en, 0);
        chk("idle_wr_sel", bus.wr_sel, 0);
        chk("idle_gnt0", bus0.gnt, 0);
        chk("idle_wr_en0", bus0.wr_en, 0);
        chk("idle_wr_sel0", bus0.wr_sel, 0);
      end
      chk("wr_addr", bus.wr_addr, hold_addr);
      chk("wr_data", bus.wr_data, hold_data);
      chk("wr_addr0", bus0.wr_addr, hold_addr);
      chk("wr_data0", bus0.wr_data, hold_data);
    end
  end

  // amode: <0 random address, 8 address = requester index, else fixed address.
  task automatic drive(input logic [NREQ-1:0] newm, input int amode);
    for (int i = 0; i < NREQ; i++) begin
      if (last_gnt[i]) begin
        owed[i] = 1'b0;
      end else if (!owed[i]) begin
        if (newm[i]) begin
          owed[i]    = 1'b1;
          bus.req[i] = 1'b1;
          if (amode < 0)       bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(NSEL - 1));
          else if (amode == 8) bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
          else                 bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(amode);
          bus.req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        end else begin
          bus.req[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && owed != '0; t++) drive('0, 0);
    chk("drain", owed, '0);
  endtask

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0; bus.stall = 1'b0;
    owed = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) drive('0, 0);
    // single write to address 5
    drive(4'b0001, 5);
    repeat (3) drive('0, 0);
    // all four requesting continuously, addresses 0..3
    repeat (10) drive(4'b1111, 8);
    drain();
    // lone requester is granted only on alternate cycles
    repeat (6) drive(4'b0100, 2);
    drain();
    // stall holds off arbitration while requests are pending
    bus.stall = 1'b1;
    repeat (3) drive(4'b0011, 1);
    bus.stall = 1'b0;
    drain();
    // zero register
    drive(4'b0001, 7);
    drain();
    // random traffic
    repeat (400) begin
      bus.stall = ($urandom_range(4) == 0);
      drive(NREQ'($urandom), -1);
    end
    bus.stall = 1'b0;
    drain();
    repeat (2) drive('0, 0);
    // reset in the middle of a write
    drive(4'b0100, 3);
    chk("pre_rst_gnt", bus.gnt, 4'b0100);
    #1 reset = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_sel", bus.wr_sel, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    bus.req = '0; owed = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (5) drive('0, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter and scheduler for the register-file write port in the pipelined processor. Up to NREQ writeback sources (ALU, load, multiply, …) compete for one write port each cycle. The block picks one winner per cycle and registers its address and data. It then drives the bank's one-hot write-enable vector, doing the 3-to-8 address decode itself, and returns a one-cycle grant to the winner. A pipeline stall input freezes new grants, and an optional hardwired zero register silently absorbs writes.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- ADDR_W, 3: register address width; the bank has 2**ADDR_W entries (8 by default).
- DATA_W, 64: write data width.
- ZR_EN, 1: when 1, address 2**ADDR_W-1 is the zero register and is never written.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester write request; level-held until granted.
- req_addr  in  NREQ*ADDR_W  packed destination addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  packed write data; same packing as req_addr.
- stall  in  1  when 1, no new arbitration or capture this cycle.
- gnt  out  NREQ  one-hot grant; a 1-cycle pulse, registered.
- wr_en  out  1  global write enable to the bank, registered.
- wr_sel  out  2**ADDR_W  one-hot decoded write select, registered; all zero when wr_en=0.
- wr_addr  out  ADDR_W  registered write address.
- wr_data  out  DATA_W  registered write data.
- busy  out  1  combinational: some eligible req is pending while stall=1.

## Operation
- Eligible set = req & ~gnt. A requester shown gnt this cycle is masked, so it cannot be double-granted while it drops req.
- Round-robin pointer ptr (log2 NREQ bits, reset 0). The search starts at ptr and wraps modulo NREQ. The first eligible index is the winner w.
- Capture, when stall=0 and the eligible set is non-empty:
  - next gnt = one-hot(w)
  - next wr_addr = addr[w], next wr_data = data[w]
  - ptr ← (w+1) mod NREQ
- wr_en / wr_sel on capture:
  - Normally next wr_en=1 and next wr_sel=one-hot(addr[w]).
  - If ZR_EN=1 and addr[w]=2**ADDR_W-1: next wr_en=0 and wr_sel=0, but gnt still pulses (the write is acknowledged and discarded).
- No capture (stall=1 or nothing eligible): next gnt=0, wr_en=0, wr_sel=0. wr_addr and wr_data hold their last values. ptr holds.
- Each capture produces exactly one write cycle; there is no multi-cycle hold.
- Requester contract: req, addr and data stay stable from assertion through the cycle gnt is seen. req may drop or re-assert, with new addr/data, in the cycle after gnt.
- Invariants, checked by assertions:
  - $onehot0(gnt) and $onehot0(wr_sel).
  - wr_sel nonzero implies wr_en=1.
  - wr_en=1 implies gnt nonzero.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk): gnt=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, ptr=0.
  - Reset mid-operation drops any in-flight write; that write is never performed.
  - The first capture is possible on the first rising edge after deassertion.
- Latency: req sampled at edge N → gnt, wr_en, wr_sel, wr_addr and wr_data valid during cycle N+1, for exactly one cycle.
- Throughput: one write per cycle with ≥2 active requesters. A single continuously requesting source gets at most one grant every 2 cycles, because of gnt masking.
- stall acts at the sampling edge. A write already on the outputs completes normally; stall does not extend or cancel it.
- Simultaneous requests: the winner is the first eligible index at or after ptr. With all NREQ requesting continuously, each is served exactly once per NREQ grants.
- Pointer wrap: a winner at NREQ-1 sets ptr=0.

## Test plan
- Reset/idle: hold reset low mid-write → gnt, wr_en and wr_sel read 0 immediately. After release with req=0 for 5 cycles, all outputs stay 0.
- Single write: req=0001, addr0=5, data0=0xAB at edge N → in cycle N+1, gnt=0001, wr_en=1, wr_sel=8'b0010_0000, wr_data=0xAB. All three return to 0 at N+2.
- Round robin: req=1111 held continuously, addresses 0..3 → grants 0001, 0010, 0100, 1000, 0001, …. Each wr_sel matches the granted requester's address.
- Self-masking: only requester 2 holds req high for 6 cycles → gnt=0100 on alternate cycles only, giving 3 writes.
- Stall: req=0011 with stall=1 for 3 cycles → busy=1, gnt=0, wr_en=0. After stall drops, the next grant follows ptr order and busy=0.
- Zero register (ZR_EN=1): addr=7 → gnt pulses, wr_en=0, wr_sel=0. With ZR_EN=0, addr=7 → wr_sel=8'b1000_0000.
